// File: rtl/lcd_hex_panel_if.sv
// Bus bundle between the debug panel driver and its host/LCD sides.
// The panel uses the slave modport; the host (board top or bench) uses master.
interface lcd_hex_panel_if #(
    parameter int unsigned NPAGES = 4
);
    localparam int unsigned SEL_W = (NPAGES > 1) ? $clog2(NPAGES) : 1;

    logic [NPAGES*128-1:0] data_in;
    logic [SEL_W-1:0]      page_sel;
    logic                  refresh;
    logic                  busy;
    logic                  ready;
    logic                  done;
    logic                  lcd_rs;
    logic                  lcd_rw;
    logic                  lcd_e;
    logic [3:0]            lcd_d;

    modport master (
        output data_in, page_sel, refresh,
        input  busy, ready, done, lcd_rs, lcd_rw, lcd_e, lcd_d
    );

    modport slave (
        input  data_in, page_sel, refresh,
        output busy, ready, done, lcd_rs, lcd_rw, lcd_e, lcd_d
    );
endinterface

// File: rtl/lcd_hex_panel.sv
// HD44780 16x2 driver (4-bit bus): power-on init, then renders a 128-bit page as 32 hex chars.
// Optional LCD_ZERO_BLANK_EN: leading zeros of each 32-bit word are shown as spaces.
module lcd_hex_panel #(
    parameter int unsigned NPAGES   = 4,
    parameter int unsigned T_PWRUP  = 750000,
    parameter int unsigned T_E      = 12,
    parameter int unsigned T_CMD    = 2000,
    parameter int unsigned T_CLR    = 250000,
    parameter int unsigned AUTO_REF = 0
) (
    input  logic            clk,
    input  logic            reset,
    lcd_hex_panel_if.slave  bus
);
    localparam int unsigned SEL_W = (NPAGES > 1) ? $clog2(NPAGES) : 1;
    localparam int unsigned MAX_A = (T_PWRUP > T_CLR) ? T_PWRUP : T_CLR;
    localparam int unsigned MAX_B = (T_CMD > T_E) ? T_CMD : T_E;
    localparam int unsigned MAX_T = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    localparam int unsigned CNT_W = $clog2(MAX_T + 1);
    localparam int unsigned AR_W  = (AUTO_REF > 1) ? $clog2(AUTO_REF) : 1;

    typedef enum logic [2:0] {
        S_PWRUP, S_LOAD, S_SETUP, S_HIGH, S_HOLD, S_WAIT, S_DONE, S_IDLE
    } state_t;

    state_t           state, state_nx;
    logic [CNT_W-1:0] cnt, cnt_nx, lim;
    logic [5:0]       idx, idx_nx;
    logic [7:0]       byte_q, byte_nx;
    logic [127:0]     snap;
    logic             snap_ld, tick, req, auto_req;
    logic             hi, hi_nx, in_init, in_init_nx, long_w, long_nx;
    logic             item_rs, item_rs_nx, pend, pend_nx;
    logic             ready_q, ready_nx, busy_q, busy_nx, done_q, done_nx;
    logic             rs_q, rs_nx, e_q, e_nx;
    logic [3:0]       d_q, d_nx, cur_nib;
    logic [SEL_W-1:0] pg;
    logic [4:0]       ni;
    logic [3:0]       nib;
    logic             blank;
    logic [7:0]       chr, it_byte;
    logic             it_rs, it_two, it_long;

    assign req     = bus.refresh | auto_req;
    assign pg      = (32'(bus.page_sel) < NPAGES) ? bus.page_sel : '0;
    assign cur_nib = hi ? byte_q[7:4] : byte_q[3:0];

    // Character slot: frame bytes 1..16 and 18..33 map to nibbles 0..31, MSB first
    assign ni  = (idx <= 6'd16) ? 5'(idx - 6'd1) : 5'(idx - 6'd2);
    assign nib = snap[{~ni, 2'b00} +: 4];

`ifdef LCD_ZERO_BLANK_EN
    logic [31:0] word, lead;
    assign word  = snap[{~ni[4:3], 5'b00000} +: 32];
    assign lead  = word >> {~ni[2:0], 2'b00};
    assign blank = (lead == 32'd0) && (ni[2:0] != 3'd7);
`else
    assign blank = 1'b0;
`endif

    assign chr = blank ? 8'h20 : (nib < 4'd10) ? {4'h3, nib} : 8'(nib) + 8'h37;

    // Item decode: which byte/nibble is sent for the current index
    always_comb begin
        it_byte = chr;
        it_rs   = 1'b1;
        it_two  = 1'b1;
        it_long = 1'b0;
        if (in_init) begin
            it_rs = 1'b0;
            if (idx < 6'd4) begin
                it_two  = 1'b0;
                it_long = 1'b1;
                it_byte = (idx == 6'd3) ? 8'h02 : 8'h03;
            end else begin
                case (idx[1:0])
                    2'd0:    it_byte = 8'h28;
                    2'd1:    it_byte = 8'h06;
                    2'd2:    it_byte = 8'h0C;
                    default: begin
                        it_byte = 8'h01;
                        it_long = 1'b1;
                    end
                endcase
            end
        end else if (idx == 6'd0) begin
            it_byte = 8'h80;
            it_rs   = 1'b0;
        end else if (idx == 6'd17) begin
            it_byte = 8'hC0;
            it_rs   = 1'b0;
        end
    end

    always_comb begin
        case (state)
            S_PWRUP:                 lim = CNT_W'(T_PWRUP);
            S_SETUP, S_HIGH, S_HOLD: lim = CNT_W'(T_E);
            S_WAIT:                  lim = long_w ? CNT_W'(T_CLR) : CNT_W'(T_CMD);
            default:                 lim = CNT_W'(1);
        endcase
        tick = (cnt == lim - 1'b1);
    end

    // Next state, datapath and output values
    always_comb begin
        state_nx   = state;
        cnt_nx     = tick ? '0 : cnt + 1'b1;
        idx_nx     = idx;
        byte_nx    = byte_q;
        hi_nx      = hi;
        in_init_nx = in_init;
        long_nx    = long_w;
        item_rs_nx = item_rs;
        pend_nx    = pend;
        ready_nx   = ready_q;
        snap_ld    = 1'b0;
        rs_nx      = rs_q;
        d_nx       = d_q;
        e_nx       = 1'b0;
        busy_nx    = 1'b1;
        done_nx    = 1'b0;
        if (req && state != S_IDLE) pend_nx = 1'b1;
        case (state)
            S_PWRUP: if (tick) begin
                state_nx   = S_LOAD;
                in_init_nx = 1'b1;
                idx_nx     = '0;
            end
            S_LOAD: begin
                byte_nx    = it_byte;
                item_rs_nx = it_rs;
                hi_nx      = it_two;
                long_nx    = it_long;
                state_nx   = S_SETUP;
            end
            S_SETUP: begin
                rs_nx = item_rs;
                d_nx  = cur_nib;
                if (tick) state_nx = S_HIGH;
            end
            S_HIGH: begin
                e_nx = 1'b1;
                if (tick) state_nx = S_HOLD;
            end
            S_HOLD: if (tick) begin
                if (hi) begin
                    hi_nx    = 1'b0;
                    state_nx = S_SETUP;
                end else begin
                    state_nx = S_WAIT;
                end
            end
            S_WAIT: if (tick) begin
                idx_nx = idx + 6'd1;
                if (in_init && idx == 6'd7) begin
                    // init finished: force the first frame through the pending path
                    in_init_nx = 1'b0;
                    ready_nx   = 1'b1;
                    pend_nx    = 1'b1;
                    state_nx   = S_IDLE;
                end else if (!in_init && idx == 6'd33) begin
                    state_nx = S_DONE;
                end else begin
                    state_nx = S_LOAD;
                end
            end
            S_DONE: begin
                done_nx  = 1'b1;
                state_nx = S_IDLE;
            end
            S_IDLE: begin
                busy_nx = 1'b0;
                if (req || pend) begin
                    pend_nx  = 1'b0;
                    snap_ld  = 1'b1;
                    idx_nx   = '0;
                    state_nx = S_LOAD;
                end
            end
            default: state_nx = S_PWRUP;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= S_PWRUP;
            cnt     <= '0;
            idx     <= '0;
            byte_q  <= '0;
            hi      <= 1'b0;
            in_init <= 1'b0;
            long_w  <= 1'b0;
            item_rs <= 1'b0;
            pend    <= 1'b0;
            snap    <= '0;
            ready_q <= 1'b0;
            busy_q  <= 1'b1;
            done_q  <= 1'b0;
            rs_q    <= 1'b0;
            e_q     <= 1'b0;
            d_q     <= '0;
        end else begin
            state   <= state_nx;
            cnt     <= cnt_nx;
            idx     <= idx_nx;
            byte_q  <= byte_nx;
            hi      <= hi_nx;
            in_init <= in_init_nx;
            long_w  <= long_nx;
            item_rs <= item_rs_nx;
            pend    <= pend_nx;
            if (snap_ld) snap <= bus.data_in[32'(pg)*128 +: 128];
            ready_q <= ready_nx;
            busy_q  <= busy_nx;
            done_q  <= done_nx;
            rs_q    <= rs_nx;
            e_q     <= e_nx;
            d_q     <= d_nx;
        end
    end

    // Periodic refresh request once the display is ready
    generate
        if (AUTO_REF > 0) begin : g_auto
            logic [AR_W-1:0] ar_cnt;
            logic            ar_req;
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    ar_cnt <= '0;
                    ar_req <= 1'b0;
                end else if (ready_q) begin
                    if (ar_cnt == AR_W'(AUTO_REF - 1)) begin
                        ar_cnt <= '0;
                        ar_req <= 1'b1;
                    end else begin
                        ar_cnt <= ar_cnt + 1'b1;
                        ar_req <= 1'b0;
                    end
                end
            end
            assign auto_req = ar_req;
        end else begin : g_no_auto
            assign auto_req = 1'b0;
        end
    endgenerate

    assign bus.busy   = busy_q;
    assign bus.ready  = ready_q;
    assign bus.done   = done_q;
    assign bus.lcd_rs = rs_q;
    assign bus.lcd_rw = 1'b0;
    assign bus.lcd_e  = e_q;
    assign bus.lcd_d  = d_q;
endmodule
